datapath_ctrl: RTL
==================

// Module: datapath_ctrl
// PURPOSE
//  Multi-cycle sequencer that drives the lab-5 datapath's control inputs. Accepts one 16-bit
//  instruction (plus 16-bit immediate) per valid/ready handshake and issues the load/select/write
//  strobes over 1-4 cycles. Sits upstream of datapath; its outputs connect 1:1 to the datapath ports.
// PARAMETERS
//  none (widths fixed by datapath: 16-bit data, 8 registers, 2-bit shift/ALUop)
// PORTS
//  clk          in   1   rising-edge clock
//  reset        in   1   asynchronous, active-high reset
//  in_valid     in   1   instr/imm valid
//  in_ready     out  1   controller idle, can accept
//  instr        in   16  [15:13]op [12:11]ALUop [10:8]Rn [7:5]Rd [4:3]shift [2:0]Rm
//  imm          in   16  immediate for MOVI
//  done         out  1   1-cycle pulse in the last cycle of an instruction
//  err          out  1   with done: illegal opcode
//  datapath_in  out  16  latched imm
//  vsel, write, loada, loadb, loadc, loads, asel, bsel  out 1 each
//  writenum, readnum  out 3;  shift, ALUop  out 2
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, instr/imm regs=0; every output 0 except in_ready=1.
//  - Handshake: accept on rising edge with in_valid&&in_ready; latch instr+imm; in_ready=1 only in
//    IDLE. in_valid while busy ignored; instr/imm may change freely after acceptance.
//  - Moore outputs: all controls decoded from state + latched regs only; no input->output comb path.
//  - Opcodes: 110 MOVI, 100 MOVR, 101 ALU; all others illegal.
//  - Sequences (one state per cycle, IDLE after last):
//    MOVI: WRIM: vsel=1, write=1, writenum=Rd, done=1.                        (1 cycle)
//    ALU:  LDA: readnum=Rn, loada=1 -> LDB: readnum=Rm, loadb=1 ->
//          EXE: asel=0, bsel=0, shift, ALUop, loadc=1, loads=1 ->
//          WB: vsel=0, write=1, writenum=Rd, done=1.                          (4 cycles)
//          ALUop=01 (CMP): EXE asserts done, no WB.                           (3 cycles)
//    MOVR: LDB(Rm) -> EXE with asel=1, ALUop=00, loads=0 -> WB.               (3 cycles)
//    Illegal: ERR state 1 cycle: done=1, err=1, no load/write strobes.
//  - Unasserted strobes 0; readnum/writenum/shift/ALUop/asel/bsel/vsel 0 outside their state.
//  - Next accept possible in the cycle after done (in_ready high once IDLE is re-entered).
//  - Reset mid-sequence: strobes drop immediately; no partial write completes; no done pulse.
// STRUCTURE
//  - lab5_pkg: opcode localparams (OP_MOVI/OP_MOVR/OP_ALU), ALUop codes (ADD/CMP/AND/MVN),
//    shift codes, state enum (IDLE,WRIM,LDA,LDB,EXE,WB,ERR), instr field bit positions.
//  - One sub-module: ctrl_decode (combinational state+instr -> control vector); top holds FSM + regs.
// TESTING (bench instantiates datapath_ctrl + datapath; checks strobes per cycle and reg contents)
//  1 MOVI R2,imm=202 -> WRIM 1 cycle: vsel=1,write=1,writenum=2, done; R2==202.
//  2 MOVI R4,51; ALU ADD R5=R2+(R4<<1) (shift=01) -> LDA,LDB,EXE,WB; datapath_out==304; R5==304.
//  3 CMP R2,R2 -> 3 cycles, loads=1 in EXE, no write strobe; Z_out==1; done in EXE.
//  4 MOVR R6=R4>>1 (shift=10) -> R6==25; loads never asserted.
//  5 in_valid held high with new instr during busy -> ignored; accepted only on cycle after done.
//  6 reset asserted mid-EXE of ALU -> same-cycle outputs 0, in_ready=1; Rd unchanged;
//    opcode 111 -> done&&err, no strobes.

Source files
------------

// File: rtl/lab5_pkg.sv
// Shared encodings for the lab-5 datapath controller: opcodes, ALU/shift codes,
// FSM states, instruction field accessors and the control-strobe bundle.
package lab5_pkg;

    localparam logic [2:0] OP_MOVI = 3'b110;
    localparam logic [2:0] OP_MOVR = 3'b100;
    localparam logic [2:0] OP_ALU  = 3'b101;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_CMP = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_MVN = 2'b11;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_ASR  = 2'b11;

    // Instruction layout: [15:13]op [12:11]ALUop [10:8]Rn [7:5]Rd [4:3]shift [2:0]Rm
    localparam int OP_LSB    = 13;
    localparam int ALUOP_LSB = 11;
    localparam int RN_LSB    = 8;
    localparam int RD_LSB    = 5;
    localparam int SH_LSB    = 3;
    localparam int RM_LSB    = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRIM,
        S_LDA,
        S_LDB,
        S_EXE,
        S_WB,
        S_ERR
    } state_t;

    typedef struct packed {
        logic       vsel;
        logic       write;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic [2:0] writenum;
        logic [2:0] readnum;
        logic [1:0] shift;
        logic [1:0] aluop;
        logic       done;
        logic       err;
    } ctrl_t;

    function automatic logic [2:0] f_op(input logic [15:0] ins);
        return ins[OP_LSB +: 3];
    endfunction

    function automatic logic [1:0] f_aluop(input logic [15:0] ins);
        return ins[ALUOP_LSB +: 2];
    endfunction

    function automatic logic [2:0] f_rn(input logic [15:0] ins);
        return ins[RN_LSB +: 3];
    endfunction

    function automatic logic [2:0] f_rd(input logic [15:0] ins);
        return ins[RD_LSB +: 3];
    endfunction

    function automatic logic [1:0] f_shift(input logic [15:0] ins);
        return ins[SH_LSB +: 2];
    endfunction

    function automatic logic [2:0] f_rm(input logic [15:0] ins);
        return ins[RM_LSB +: 3];
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational decode of FSM state plus latched instruction into the datapath
// control strobes; every strobe is 0 outside the state that owns it.
module ctrl_decode
    import lab5_pkg::*;
(
    input  state_t      state_i,
    input  logic [15:0] instr_i,
    output ctrl_t       ctrl_o
);

    logic is_movr;
    logic is_cmp;

    assign is_movr = (f_op(instr_i) == OP_MOVR);
    assign is_cmp  = (f_op(instr_i) == OP_ALU) && (f_aluop(instr_i) == ALU_CMP);

    always_comb begin
        // NOTE: default every field first so no path through the case infers a latch.
        ctrl_o = '0;
        unique case (state_i)
            S_WRIM: begin
                ctrl_o.vsel     = 1'b1;
                ctrl_o.write    = 1'b1;
                ctrl_o.writenum = f_rd(instr_i);
                ctrl_o.done     = 1'b1;
            end
            S_LDA: begin
                ctrl_o.readnum = f_rn(instr_i);
                ctrl_o.loada   = 1'b1;
            end
            S_LDB: begin
                ctrl_o.readnum = f_rm(instr_i);
                ctrl_o.loadb   = 1'b1;
            end
            S_EXE: begin
                ctrl_o.shift = f_shift(instr_i);
                ctrl_o.loadc = 1'b1;
                if (is_movr) begin
                    // A-side forced to zero so ADD passes the shifted Rm through.
                    ctrl_o.asel  = 1'b1;
                    ctrl_o.aluop = ALU_ADD;
                end else begin
                    ctrl_o.aluop = f_aluop(instr_i);
                    ctrl_o.loads = 1'b1;
                    ctrl_o.done  = is_cmp;
                end
            end
            S_WB: begin
                ctrl_o.write    = 1'b1;
                ctrl_o.writenum = f_rd(instr_i);
                ctrl_o.done     = 1'b1;
            end
            S_ERR: begin
                ctrl_o.done = 1'b1;
                ctrl_o.err  = 1'b1;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/datapath_ctrl.sv
// Multi-cycle sequencer for the lab-5 datapath: one instruction per valid/ready
// handshake, Moore-decoded strobes issued over 1-4 cycles.
module datapath_ctrl
    import lab5_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] instr,
    input  logic [15:0] imm,
    output logic        done,
    output logic        err,
    output logic [15:0] datapath_in,
    output logic        vsel,
    output logic        write,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [2:0]  writenum,
    output logic [2:0]  readnum,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop
);

    state_t      state_q, state_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] imm_q, imm_d;
    logic        accept;
    ctrl_t       ctrl;

    assign in_ready = (state_q == S_IDLE);
    assign accept   = in_valid && in_ready;

    // NOTE: asynchronous reset in the sensitivity list drops every strobe at once,
    // even mid-sequence, so no partial write can complete.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            instr_q <= '0;
            imm_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments keep all state updates parallel at the edge.
            state_q <= state_d;
            instr_q <= instr_d;
            imm_q   <= imm_d;
        end
    end

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        imm_d   = imm_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    instr_d = instr;
                    imm_d   = imm;
                    unique case (f_op(instr))
                        OP_MOVI: state_d = S_WRIM;
                        OP_ALU:  state_d = S_LDA;
                        OP_MOVR: state_d = S_LDB;
                        default: state_d = S_ERR;
                    endcase
                end
            end
            S_LDA: state_d = S_LDB;
            S_LDB: state_d = S_EXE;
            S_EXE: begin
                // CMP only updates status, so it finishes without a write-back.
                if ((f_op(instr_q) == OP_ALU) && (f_aluop(instr_q) == ALU_CMP)) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WB;
                end
            end
            S_WRIM, S_WB, S_ERR: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    ctrl_decode u_decode (
        .state_i (state_q),
        .instr_i (instr_q),
        .ctrl_o  (ctrl)
    );

    assign datapath_in = imm_q;
    assign vsel        = ctrl.vsel;
    assign write       = ctrl.write;
    assign loada       = ctrl.loada;
    assign loadb       = ctrl.loadb;
    assign loadc       = ctrl.loadc;
    assign loads       = ctrl.loads;
    assign asel        = ctrl.asel;
    assign bsel        = ctrl.bsel;
    assign writenum    = ctrl.writenum;
    assign readnum     = ctrl.readnum;
    assign shift       = ctrl.shift;
    assign ALUop       = ctrl.aluop;
    assign done        = ctrl.done;
    assign err         = ctrl.err;

endmodule
